// File: rtl/cache_mem_responder.sv
// Memory-side responder that arbitrates icache/dcache single-word requests onto one RAM port,
// holding the grant until RAM reports ACCESS, ERROR, or the wait budget runs out.
module cache_mem_responder #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    // wait_ct counts wait cycles already spent, so the current cycle is the TIMEOUT-th one
    // when the count reads TIMEOUT-1.
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [2:0]        STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [1:0]        RAM_ACCESS = 2'd2;
    localparam logic [1:0]        RAM_ERROR  = 2'd3;
    localparam logic [31:0]       ADDR_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              serv_s;
    logic              done_ok_s;
    logic              fail_s;
    logic              finish_s;
    logic              force_i_s;
    logic              grant_d_s;
    logic              grant_i_s;
    logic [WAIT_W-1:0] wait_ct_r;
    logic [2:0]        starve_ct_r;
    logic              ram_ren_r;
    logic              ram_wen_r;
    logic [31:0]       ram_addr_r;
    logic [31:0]       ram_store_r;
    logic              mem_err_r;

    assign ramREN   = ram_ren_r;
    assign ramWEN   = ram_wen_r;
    assign ramaddr  = ram_addr_r & ADDR_MASK;
    assign ramstore = ram_store_r;
    assign mem_err  = mem_err_r;

    // Completion decode, arbitration and next-state selection
    always_comb begin
        serv_s       = (state_r != IDLE);
        done_ok_s    = serv_s && (ramstate == RAM_ACCESS);
        fail_s       = serv_s && ((ramstate == RAM_ERROR) ||
                                  ((ramstate != RAM_ACCESS) && (wait_ct_r == WAIT_LAST)));
        finish_s     = done_ok_s || fail_s;
        force_i_s    = (starve_ct_r == STARVE_MAX) && iREN;
        grant_d_s    = 1'b0;
        grant_i_s    = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (force_i_s) begin
                    grant_i_s    = 1'b1;
                    state_next_s = ISERV;
                end else if (dREN || dWEN) begin
                    grant_d_s    = 1'b1;
                    state_next_s = DSERV;
                end else if (iREN) begin
                    grant_i_s    = 1'b1;
                    state_next_s = ISERV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DSERV, ISERV: begin
                if (finish_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Cache-side handshake: only the granted cache sees its wait drop, and only on completion
    always_comb begin
        iwait = 1'b1;
        dwait = 1'b1;
        iload = 32'h0000_0000;
        dload = 32'h0000_0000;
        if ((state_r == ISERV) && finish_s) begin
            iwait = 1'b0;
            iload = done_ok_s ? ramload : 32'h0000_0000;
        end else if ((state_r == DSERV) && finish_s) begin
            dwait = 1'b0;
            dload = (done_ok_s && !ram_wen_r) ? ramload : 32'h0000_0000;
        end else begin
            iwait = 1'b1;
            dwait = 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latched request: strobes, address and data are frozen for the whole service
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ram_ren_r   <= 1'b0;
            ram_wen_r   <= 1'b0;
            ram_addr_r  <= 32'h0000_0000;
            ram_store_r <= 32'h0000_0000;
        end else if (grant_d_s) begin
            ram_ren_r   <= !dWEN;
            ram_wen_r   <= dWEN;
            ram_addr_r  <= daddr;
            ram_store_r <= dstore;
        end else if (grant_i_s) begin
            ram_ren_r   <= 1'b1;
            ram_wen_r   <= 1'b0;
            ram_addr_r  <= iaddr;
            ram_store_r <= 32'h0000_0000;
        end else if (finish_s) begin
            ram_ren_r   <= 1'b0;
            ram_wen_r   <= 1'b0;
        end
    end

    // Wait budget for the access in flight
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wait_ct_r <= '0;
        end else if (grant_d_s || grant_i_s) begin
            wait_ct_r <= '0;
        end else if (serv_s && !finish_s) begin
            wait_ct_r <= wait_ct_r + WAIT_W'(1);
        end
    end

    // Fairness: consecutive dcache wins while the icache is kept waiting
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starve_ct_r <= 3'd0;
        end else if (grant_i_s || !iREN) begin
            starve_ct_r <= 3'd0;
        end else if (grant_d_s && (starve_ct_r != STARVE_MAX)) begin
            starve_ct_r <= starve_ct_r + 3'd1;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            mem_err_r <= 1'b0;
        end else if (fail_s) begin
            mem_err_r <= 1'b1;
        end
    end

endmodule
